// File: rtl/input_mem.sv
// ============================================================================
// Module      : input_mem
// Description : Read-side pixel buffer. Unpacks 32-bit bus words into a byte
//               buffer and serves random-access B/G/R bytes to the datapath.
//               Optional macro INPUT_MEM_LITTLE_ENDIAN_EN selects the
//               little-endian byte mapping of each bus word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_mem #(
    parameter int DEPTH_BYTES = 64,
    parameter int ADDR_W      = 8
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET_N,
    input  logic [31:0]       I_RDATA,
    input  logic              I_RDATA_VALID,
    output logic              O_RDATA_READY,
    output logic              O_BUF_FULL,
    input  logic              I_PIXEL_RD,
    input  logic [ADDR_W-1:0] I_PIXEL_ADDRB,
    input  logic [ADDR_W-1:0] I_PIXEL_ADDRG,
    input  logic [ADDR_W-1:0] I_PIXEL_ADDRR,
    output logic [7:0]        O_PIXEL_B,
    output logic [7:0]        O_PIXEL_G,
    output logic [7:0]        O_PIXEL_R,
    output logic              O_PIXEL_VALID,
    input  logic              I_BLOCK_DONE
);

    localparam int                c_words    = DEPTH_BYTES / 4;
    localparam int                c_cnt_w    = (c_words > 1) ? $clog2(c_words) : 1;
    localparam int                c_idx_w    = c_cnt_w + 2;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_words - 1);
    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W + 1)'(DEPTH_BYTES);

    localparam logic [0:0] c_st_fill = 1'b0;
    localparam logic [0:0] c_st_full = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ready;
    logic               r_full;
    logic               w_ready_nxt;
    logic               w_full_nxt;
    logic               w_beat;
    logic               w_last_beat;
    logic               w_rd;
    logic               w_release;
    logic [7:0]         w_byte_b;
    logic [7:0]         w_byte_g;
    logic [7:0]         w_byte_r;
    logic [7:0]         r_pix_b;
    logic [7:0]         r_pix_g;
    logic [7:0]         r_pix_r;
    logic               r_pix_valid;
    logic [7:0]         r_mem [DEPTH_BYTES];

    // A beat requires the registered READY, so nothing is taken during reset
    // or in the cycle after the last beat.
    assign w_beat      = I_RDATA_VALID & r_ready;
    assign w_last_beat = w_beat & (r_cnt == c_last_cnt);
    assign w_release   = (r_state == c_st_full) & I_BLOCK_DONE;

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            r_state <= c_st_fill;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_fill: if (w_last_beat) w_state_nxt = c_st_full;
            c_st_full: if (I_BLOCK_DONE) w_state_nxt = c_st_fill;
            default:   w_state_nxt = c_st_fill;
        endcase
    end

    always_comb begin
        w_ready_nxt = (w_state_nxt == c_st_fill);
        w_full_nxt  = (w_state_nxt == c_st_full);
        w_rd        = I_PIXEL_RD & (r_state == c_st_full);
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            r_ready <= 1'b0;
            r_full  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_ready <= w_ready_nxt;
            r_full  <= w_full_nxt;
            if (w_beat) begin
                r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
            end else if (w_release) begin
                r_cnt <= '0;
            end
        end
    end

    // Buffer storage carries no reset; a new block always overwrites it fully.
    always_ff @(posedge I_HCLK) begin
        if (w_beat) begin
            for (int j = 0; j < 4; j++) begin
`ifdef INPUT_MEM_LITTLE_ENDIAN_EN
                r_mem[{r_cnt, 2'(j)}] <= I_RDATA[8*j +: 8];
`else
                r_mem[{r_cnt, 2'(j)}] <= I_RDATA[31-8*j -: 8];
`endif
            end
        end
    end

    function automatic logic [7:0] f_rd_byte(input logic [ADDR_W-1:0] a);
        logic [7:0] v;
        v = 8'h00;
        if ({1'b0, a} < c_depth) begin
            v = r_mem[a[c_idx_w-1:0]];
        end
        return v;
    endfunction

    always_comb begin
        w_byte_b = f_rd_byte(I_PIXEL_ADDRB);
        w_byte_g = f_rd_byte(I_PIXEL_ADDRG);
        w_byte_r = f_rd_byte(I_PIXEL_ADDRR);
    end

    // Pixel bytes hold their last value whenever no read is served.
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            r_pix_b     <= 8'h00;
            r_pix_g     <= 8'h00;
            r_pix_r     <= 8'h00;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= w_rd;
            if (w_rd) begin
                r_pix_b <= w_byte_b;
                r_pix_g <= w_byte_g;
                r_pix_r <= w_byte_r;
            end
        end
    end

    assign O_RDATA_READY = r_ready;
    assign O_BUF_FULL    = r_full;
    assign O_PIXEL_B     = r_pix_b;
    assign O_PIXEL_G     = r_pix_g;
    assign O_PIXEL_R     = r_pix_r;
    assign O_PIXEL_VALID = r_pix_valid;

endmodule

`default_nettype wire

// File: tb/tb_input_mem.sv
// Scoreboard bench for input_mem: pixel reads push expected bytes, a monitor
// pops and compares whenever O_PIXEL_VALID is presented.
`default_nettype none

module tb_input_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] I_RDATA;
    logic        I_RDATA_VALID;
    logic        O_RDATA_READY;
    logic        O_BUF_FULL;
    logic        I_PIXEL_RD;
    logic [7:0]  I_PIXEL_ADDRB;
    logic [7:0]  I_PIXEL_ADDRG;
    logic [7:0]  I_PIXEL_ADDRR;
    logic [7:0]  O_PIXEL_B;
    logic [7:0]  O_PIXEL_G;
    logic [7:0]  O_PIXEL_R;
    logic        O_PIXEL_VALID;
    logic        I_BLOCK_DONE;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pix_t;

    pix_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_mem [64];
    logic [7:0] last_b;

    always #5 clk = ~clk;

    input_mem #(.DEPTH_BYTES(64), .ADDR_W(8)) dut (
        .I_HCLK        (clk),
        .I_HRESET_N    (rst_n),
        .I_RDATA       (I_RDATA),
        .I_RDATA_VALID (I_RDATA_VALID),
        .O_RDATA_READY (O_RDATA_READY),
        .O_BUF_FULL    (O_BUF_FULL),
        .I_PIXEL_RD    (I_PIXEL_RD),
        .I_PIXEL_ADDRB (I_PIXEL_ADDRB),
        .I_PIXEL_ADDRG (I_PIXEL_ADDRG),
        .I_PIXEL_ADDRR (I_PIXEL_ADDRR),
        .O_PIXEL_B     (O_PIXEL_B),
        .O_PIXEL_G     (O_PIXEL_G),
        .O_PIXEL_R     (O_PIXEL_R),
        .O_PIXEL_VALID (O_PIXEL_VALID),
        .I_BLOCK_DONE  (I_BLOCK_DONE)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        pix_t e;
        if (O_PIXEL_VALID === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel_valid: got B=%h G=%h R=%h expected no valid at %0t",
                         O_PIXEL_B, O_PIXEL_G, O_PIXEL_R, $time);
            end else begin
                e = sb_q.pop_front();
                if ({O_PIXEL_B, O_PIXEL_G, O_PIXEL_R} !== e) begin
                    n_fail++;
                    $display("FAIL pixel_data: got B=%h G=%h R=%h expected B=%h G=%h R=%h at %0t",
                             O_PIXEL_B, O_PIXEL_G, O_PIXEL_R, e.b, e.g, e.r, $time);
                end
            end
        end
    end

    function automatic logic [31:0] word_of(input int pat, input int k);
        logic [31:0] w;
        case (pat)
            0:       w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            1:       w = 32'hFFFF_FFFF;
            default: w = 32'hAABB_CCDD + 32'(k) * 32'h0101_0101;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int j);
`ifdef INPUT_MEM_LITTLE_ENDIAN_EN
        return w[8*j +: 8];
`else
        return w[31-8*j -: 8];
`endif
    endfunction

    function automatic logic [7:0] exp_byte(input logic [7:0] a);
        return (a >= 8'd64) ? 8'h00 : exp_mem[a[5:0]];
    endfunction

    task automatic fill(input int pat, input int nbeats, input bit gaps, input bit extra);
        for (int k = 0; k < nbeats; k++) begin
            I_RDATA       = word_of(pat, k);
            I_RDATA_VALID = 1'b1;
            for (int j = 0; j < 4; j++) exp_mem[4*k+j] = byte_of(I_RDATA, j);
            @(posedge clk); #1;
            if (nbeats == 16 && k == 14) check("full_before_last", O_BUF_FULL, 0);
            if (nbeats == 16 && k == 15) begin
                check("full_after_last", O_BUF_FULL, 1);
                check("ready_after_last", O_RDATA_READY, 0);
            end
            if (gaps) begin
                I_RDATA_VALID = 1'b0;
                I_RDATA       = 32'h5A5A_5A5A;
                @(posedge clk); #1;
            end
        end
        if (extra) begin
            I_RDATA = 32'hDEAD_BEEF;
            repeat (3) begin
                @(posedge clk); #1;
                check("ready_backpressure", O_RDATA_READY, 0);
            end
        end
        I_RDATA_VALID = 1'b0;
    endtask

    task automatic read(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r, input bit done);
        pix_t e;
        I_PIXEL_RD    = 1'b1;
        I_PIXEL_ADDRB = b;
        I_PIXEL_ADDRG = g;
        I_PIXEL_ADDRR = r;
        I_BLOCK_DONE  = done;
        e.b = exp_byte(b);
        e.g = exp_byte(g);
        e.r = exp_byte(r);
        last_b = e.b;
        sb_q.push_back(e);
        @(posedge clk); #1;
        I_PIXEL_RD   = 1'b0;
        I_BLOCK_DONE = 1'b0;
        if (done) begin
            check("ready_after_release", O_RDATA_READY, 1);
            check("full_after_release", O_BUF_FULL, 0);
        end
    endtask

    task automatic midcycle_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", O_RDATA_READY, 0);
        check("rst_full", O_BUF_FULL, 0);
        check("rst_valid", O_PIXEL_VALID, 0);
        check("rst_pixels", {8'h00, O_PIXEL_B, O_PIXEL_G, O_PIXEL_R}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", O_RDATA_READY, 1);
        check("full_after_rst", O_BUF_FULL, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        I_RDATA       = '0;
        I_RDATA_VALID = 1'b0;
        I_PIXEL_RD    = 1'b0;
        I_PIXEL_ADDRB = '0;
        I_PIXEL_ADDRG = '0;
        I_PIXEL_ADDRR = '0;
        I_BLOCK_DONE  = 1'b0;
        last_b        = '0;
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;

        // Reset state and release
        @(posedge clk); #1;
        check("ready_in_reset", O_RDATA_READY, 0);
        check("full_in_reset", O_BUF_FULL, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release_rst", O_RDATA_READY, 1);
        check("full_after_release_rst", O_BUF_FULL, 0);
        midcycle_reset();

        // Plain fill and reads, including repeated address on all channels
        fill(0, 16, 1'b0, 1'b0);
        read(8'd0, 8'd5, 8'd63, 1'b0);
        read(8'd1, 8'd2, 8'd3, 1'b0);
        read(8'd60, 8'd61, 8'd62, 1'b0);
        read(8'd10, 8'd10, 8'd10, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: 17th word held valid must not land
        read(8'd0, 8'd0, 8'd0, 1'b1);
        fill(0, 16, 1'b0, 1'b1);
        read(8'd63, 8'd60, 8'd0, 1'b0);
        read(8'd2, 8'd3, 8'd4, 1'b1);

        // Reads and release during FILL are ignored, pixels hold
        I_PIXEL_RD    = 1'b1;
        I_BLOCK_DONE  = 1'b1;
        I_PIXEL_ADDRB = 8'd9;
        repeat (3) begin
            @(posedge clk); #1;
            check("valid_in_fill", O_PIXEL_VALID, 0);
            check("hold_b_in_fill", O_PIXEL_B, last_b);
            check("ready_in_fill", O_RDATA_READY, 1);
        end
        I_PIXEL_RD   = 1'b0;
        I_BLOCK_DONE = 1'b0;
        fill(0, 16, 1'b1, 1'b0);
        read(8'h3F, 8'hFF, 8'h40, 1'b0);

        // Simultaneous read and release, then refill with all-ones
        read(8'd4, 8'd5, 8'd6, 1'b1);
        fill(1, 16, 1'b0, 1'b0);
        read(8'd0, 8'd31, 8'd63, 1'b0);

        // Endianness of beat 0 and reset partway through a fill
        read(8'd7, 8'd8, 8'd9, 1'b1);
        fill(2, 7, 1'b0, 1'b0);
        midcycle_reset();
        fill(2, 16, 1'b0, 1'b0);
        read(8'd0, 8'd3, 8'd1, 1'b0);
        read(8'd28, 8'd31, 8'd2, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
